// File: rtl/key_cpu_select_pkg.sv
// Shared constants and helpers for the CPU-select push-button block.
package key_cpu_select_pkg;

    // Width of the CPU index bus; CPU_NUM may be anything in 1..2**CpuNumWidth.
    localparam int unsigned CpuNumWidth = 4;

    // Default number of selectable CPUs.
    localparam int unsigned CpuNum = 4;

    // Width of the debounce interval counter.
    localparam int unsigned CntWidth = 24;

    // Next CPU index with an explicit wrap at num-1 (never relies on overflow).
    function automatic logic [CpuNumWidth-1:0] next_cpu_sel(
        input logic [CpuNumWidth-1:0] cur,
        input int unsigned            num
    );
        logic [CpuNumWidth-1:0] last;
        last = CpuNumWidth'(num - 1);
        if (cur == last) begin
            next_cpu_sel = '0;
        end else begin
            next_cpu_sel = cur + CpuNumWidth'(1);
        end
    endfunction

endpackage

// File: rtl/key_cpu_select_debounce.sv
// Synchronises the raw active-low key and debounces it with a counter FSM.
// Emits the registered debounced level and a combinational press strobe
// that is high in the cycle the FSM commits to a new press.
module key_debounce
    import key_cpu_select_pkg::*;
#(
    parameter int unsigned DURATION = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_held,
    output logic press
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        HELD,
        WAIT_REL
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DURATION - 1);

    logic                sync1_q;
    logic                key_s;
    state_e              state_q;
    state_e              state_d;
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic                key_held_q;
    logic                key_held_d;

    // Two-flop synchronizer; reset parks both flops in the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            key_s   <= 1'b1;
        end else begin
            sync1_q <= key_n;
            key_s   <= sync1_q;
        end
    end

    // Next-state and counter logic; a press needs DURATION+1 consecutive low
    // samples (one to leave IDLE, DURATION counted in WAIT_PRESS), and a
    // release mirrors that with high samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = WAIT_PRESS;
                    cnt_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = HELD;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            HELD: begin
                if (key_s) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            end
            WAIT_REL: begin
                if (!key_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        key_held_d = (state_d == HELD) || (state_d == WAIT_REL);
    end

    // State, counter and debounced-level registers; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_held_q <= key_held_d;
        end
    end

    assign key_held = key_held_q;

endmodule

// File: rtl/key_cpu_select.sv
// Push-button CPU selector: each debounced press advances cpu_sel by one,
// wrapping at CPU_NUM-1, with a one-cycle strobe marking the change.
module key_cpu_select
    import key_cpu_select_pkg::*;
#(
    parameter int unsigned DURATION = 1_000_000,
    parameter int unsigned CPU_NUM  = CpuNum
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_n,
    output logic [CpuNumWidth-1:0] cpu_sel,
    output logic                   sel_pulse,
    output logic                   key_held
);

    logic                   press;
    logic [CpuNumWidth-1:0] cpu_sel_q;
    logic [CpuNumWidth-1:0] cpu_sel_d;
    logic                   sel_pulse_q;

    key_debounce #(
        .DURATION (DURATION)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .key_held (key_held),
        .press    (press)
    );

    // Select counter advances only on a committed press.
    always_comb begin
        cpu_sel_d = cpu_sel_q;
        if (press) begin
            cpu_sel_d = next_cpu_sel(cpu_sel_q, CPU_NUM);
        end
    end

    // Select and strobe registers; strobe is high only in the update cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_sel_q   <= '0;
            sel_pulse_q <= 1'b0;
        end else begin
            cpu_sel_q   <= cpu_sel_d;
            sel_pulse_q <= press;
        end
    end

    assign cpu_sel   = cpu_sel_q;
    assign sel_pulse = sel_pulse_q;

endmodule
